// File: rtl/uart_echo_fifo.sv
// UART transceiver: 2-FF synchronised oversampling RX, optional parity, RX FIFO, TX echo or host send.
// Good word: rx_valid/push the cycle after the stop sample; TX starts the cycle after pop/capture; a full FIFO drops words and sets overflow.
module uart_echo_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 16,
    parameter int ECHO         = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          RsRx,
    output logic                          RsTx,
    output logic [DATA_BITS-1:0]          Rx_data,
    output logic                          rx_valid,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_busy
);
    localparam int CNTW = $clog2(CLKS_PER_BIT);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CLKS_PER_BIT - 1);
    localparam logic [CNTW-1:0] CNT_HALF = CNTW'(CLKS_PER_BIT / 2 - 1);
    localparam int BITW = $clog2(DATA_BITS);
    localparam logic [BITW-1:0] BIT_LAST = BITW'(DATA_BITS - 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam int FW = DATA_BITS + 3;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t r_rx_st, w_rx_nxt, r_tx_st, w_tx_nxt;
    logic r_rx_s1, r_rx_s2, r_rx_d;
    logic [CNTW-1:0] r_rx_cnt, r_tx_cnt;
    logic [BITW-1:0] r_rx_bit, r_tx_bit;
    logic [DATA_BITS-1:0] r_rx_sh, r_rx_word;
    logic r_rx_par, r_rx_valid, r_perr, r_ferr, r_ovf;
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0] r_cnt;
    logic [FW-1:0] r_tx_frame;
    logic w_rx_tick, w_rx_half, w_rx_done, w_rx_par_ok, w_push, w_wr, w_pop, w_full;
    logic w_tx_tick, w_tx_load, w_tx_par;
    logic [DATA_BITS-1:0] w_tx_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_rx_s1 <= RsRx;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
        end
    end

    assign w_rx_tick = (r_rx_cnt == CNT_LAST);
    assign w_rx_half = (r_rx_cnt == CNT_HALF);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rx_st <= S_IDLE;
        else      r_rx_st <= w_rx_nxt;
    end

    always_comb begin
        w_rx_nxt  = r_rx_st;
        w_rx_done = 1'b0;
        case (r_rx_st)
            S_IDLE:   if (r_rx_d && !r_rx_s2) w_rx_nxt = S_START;
            S_START:  if (w_rx_half) w_rx_nxt = r_rx_s2 ? S_IDLE : S_DATA;
            S_DATA:   if (w_rx_tick && r_rx_bit == BIT_LAST) w_rx_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (w_rx_tick) w_rx_nxt = S_STOP;
            S_STOP: begin
                if (w_rx_tick) begin
                    w_rx_nxt  = S_IDLE;
                    w_rx_done = 1'b1;
                end
            end
            default:  w_rx_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rx_par_ok = 1'b1;
        if (PARITY == 1)      w_rx_par_ok = ^{r_rx_sh, r_rx_par};
        else if (PARITY == 2) w_rx_par_ok = ~^{r_rx_sh, r_rx_par};
    end

    // A low stop bit is a framing error regardless of parity.
    assign w_push = w_rx_done && r_rx_s2 && w_rx_par_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_sh    <= '0;
            r_rx_par   <= 1'b0;
            r_rx_word  <= '0;
            r_rx_valid <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_rx_valid <= w_push;
            r_perr     <= w_rx_done && r_rx_s2 && !w_rx_par_ok;
            r_ferr     <= w_rx_done && !r_rx_s2;
            if (w_push) r_rx_word <= r_rx_sh;
            if (r_rx_st == S_IDLE || w_rx_tick || (r_rx_st == S_START && w_rx_half)) r_rx_cnt <= '0;
            else                                                                    r_rx_cnt <= r_rx_cnt + 1'b1;
            if (r_rx_st == S_IDLE) r_rx_bit <= '0;
            if (r_rx_st == S_DATA && w_rx_tick) begin
                r_rx_sh  <= {r_rx_s2, r_rx_sh[DATA_BITS-1:1]};
                r_rx_bit <= r_rx_bit + 1'b1;
            end
            if (r_rx_st == S_PARITY && w_rx_tick) r_rx_par <= r_rx_s2;
        end
    end

    assign w_full = (r_cnt == FULL_CNT);
    assign w_pop  = (ECHO != 0) && (r_tx_st == S_IDLE) && (r_cnt != '0);
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_rx_sh;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    assign w_tx_tick = (r_tx_cnt == CNT_LAST);
    assign w_tx_load = (r_tx_st == S_IDLE) && ((ECHO != 0) ? (r_cnt != '0) : tx_valid);
    assign w_tx_word = (ECHO != 0) ? r_mem[r_rd_ptr] : tx_data;
    assign w_tx_par  = (PARITY == 1) ? ~^w_tx_word : ^w_tx_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_tx_st <= S_IDLE;
        else      r_tx_st <= w_tx_nxt;
    end

    always_comb begin
        w_tx_nxt = r_tx_st;
        case (r_tx_st)
            S_IDLE:   if (w_tx_load) w_tx_nxt = S_START;
            S_START:  if (w_tx_tick) w_tx_nxt = S_DATA;
            S_DATA:   if (w_tx_tick && r_tx_bit == BIT_LAST) w_tx_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (w_tx_tick) w_tx_nxt = S_STOP;
            S_STOP:   if (w_tx_tick) w_tx_nxt = S_IDLE;
            default:  w_tx_nxt = S_IDLE;
        endcase
    end

    // Whole frame is shifted out of one register so RsTx is a flop output; without parity the parity slot holds a 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_frame <= '1;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
        end else begin
            if (w_tx_load)                          r_tx_frame <= {1'b1, (PARITY != 0) ? w_tx_par : 1'b1, w_tx_word, 1'b0};
            else if (r_tx_st != S_IDLE && w_tx_tick) r_tx_frame <= {1'b1, r_tx_frame[FW-1:1]};
            if (r_tx_st == S_IDLE || w_tx_tick) r_tx_cnt <= '0;
            else                                r_tx_cnt <= r_tx_cnt + 1'b1;
            if (r_tx_st != S_DATA)  r_tx_bit <= '0;
            else if (w_tx_tick)     r_tx_bit <= r_tx_bit + 1'b1;
        end
    end

    assign RsTx       = r_tx_frame[0];
    assign Rx_data    = r_rx_word;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign overflow   = r_ovf;
    assign fifo_count = r_cnt;
    assign tx_busy    = (r_tx_st != S_IDLE);
    assign tx_ready   = (ECHO == 0) && (r_tx_st == S_IDLE);
endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo: three instances (8N1 echo, even-parity echo, depth-4 host TX) with RX/TX scoreboards.
module tb_uart_echo_fifo;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] rsrx = 3'b111;
    logic tx0, tx1, tx2;
    logic [7:0] rxd0, rxd1, rxd2;
    logic rxv0, rxv1, rxv2, perr0, perr1, perr2, ferr0, ferr1, ferr2, ovf0, ovf1, ovf2;
    logic [4:0] fc0, fc1;
    logic [2:0] fc2;
    logic rdy0, rdy1, rdy2, busy0, busy1, busy2;
    logic [7:0] txd_na = 8'h00;
    logic txv_na = 1'b0;
    logic [7:0] txd2 = 8'h00;
    logic txv2 = 1'b0;

    int total = 0;
    int bad = 0;
    int epoch = 0;
    int n_perr [3] = '{0, 0, 0};
    int n_ferr [3] = '{0, 0, 0};
    logic [7:0] q_rx0[$], q_rx1[$], q_rx2[$], q_tx0[$], q_tx1[$], q_tx2[$];

    uart_echo_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(16), .ECHO(1)) u0 (
        .clk(clk), .rst(rst), .RsRx(rsrx[0]), .RsTx(tx0), .Rx_data(rxd0), .rx_valid(rxv0),
        .parity_err(perr0), .frame_err(ferr0), .overflow(ovf0), .fifo_count(fc0),
        .tx_data(txd_na), .tx_valid(txv_na), .tx_ready(rdy0), .tx_busy(busy0));
    uart_echo_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(16), .ECHO(1)) u1 (
        .clk(clk), .rst(rst), .RsRx(rsrx[1]), .RsTx(tx1), .Rx_data(rxd1), .rx_valid(rxv1),
        .parity_err(perr1), .frame_err(ferr1), .overflow(ovf1), .fifo_count(fc1),
        .tx_data(txd_na), .tx_valid(txv_na), .tx_ready(rdy1), .tx_busy(busy1));
    uart_echo_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4), .ECHO(0)) u2 (
        .clk(clk), .rst(rst), .RsRx(rsrx[2]), .RsTx(tx2), .Rx_data(rxd2), .rx_valid(rxv2),
        .parity_err(perr2), .frame_err(ferr2), .overflow(ovf2), .fifo_count(fc2),
        .tx_data(txd2), .tx_valid(txv2), .tx_ready(rdy2), .tx_busy(busy2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic line(input int i);
        case (i)
            0:       return tx0;
            1:       return tx1;
            default: return tx2;
        endcase
    endfunction

    task automatic rx_sb(input int i, input logic [7:0] got);
        logic [7:0] e;
        int n;
        n = (i == 0) ? q_rx0.size() : (i == 1) ? q_rx1.size() : q_rx2.size();
        if (n == 0) begin
            check($sformatf("rx%0d_spurious_word", i), 32'(got), 32'hFFFF_FFFF);
        end else begin
            case (i)
                0:       e = q_rx0.pop_front();
                1:       e = q_rx1.pop_front();
                default: e = q_rx2.pop_front();
            endcase
            check($sformatf("rx%0d_word", i), 32'(got), 32'(e));
        end
    endtask

    task automatic tx_sb(input int i, input logic [7:0] d, input logic p, input logic st, input logic sp, input int npar);
        logic [7:0] e;
        int n;
        n = (i == 0) ? q_tx0.size() : (i == 1) ? q_tx1.size() : q_tx2.size();
        check($sformatf("tx%0d_start_bit", i), 32'(st), 32'd0);
        check($sformatf("tx%0d_stop_bit", i), 32'(sp), 32'd1);
        if (n == 0) begin
            check($sformatf("tx%0d_spurious_frame", i), 32'(d), 32'hFFFF_FFFF);
        end else begin
            case (i)
                0:       e = q_tx0.pop_front();
                1:       e = q_tx1.pop_front();
                default: e = q_tx2.pop_front();
            endcase
            check($sformatf("tx%0d_word", i), 32'(d), 32'(e));
            if (npar == 2) check($sformatf("tx%0d_even_parity", i), 32'(p), 32'(^e));
        end
    endtask

    task automatic tx_mon(input int i, input int npar);
        logic [7:0] d;
        logic p, st, sp;
        int ep;
        @(posedge rst);
        forever begin
            @(negedge clk);
            if (line(i) !== 1'b0) continue;
            ep = epoch;
            repeat (CPB / 2) @(negedge clk);
            st = line(i);
            for (int b = 0; b < 8; b++) begin
                repeat (CPB) @(negedge clk);
                d[b] = line(i);
            end
            p = 1'b0;
            if (npar != 0) begin
                repeat (CPB) @(negedge clk);
                p = line(i);
            end
            repeat (CPB) @(negedge clk);
            sp = line(i);
            if (ep != epoch) continue;
            tx_sb(i, d, p, st, sp, npar);
        end
    endtask

    initial tx_mon(0, 0);
    initial tx_mon(1, 2);
    initial tx_mon(2, 0);

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (rxv0 === 1'b1) rx_sb(0, rxd0);
            if (rxv1 === 1'b1) rx_sb(1, rxd1);
            if (rxv2 === 1'b1) rx_sb(2, rxd2);
            if (perr0 === 1'b1) n_perr[0]++;
            if (perr1 === 1'b1) n_perr[1]++;
            if (perr2 === 1'b1) n_perr[2]++;
            if (ferr0 === 1'b1) n_ferr[0]++;
            if (ferr1 === 1'b1) n_ferr[1]++;
            if (ferr2 === 1'b1) n_ferr[2]++;
        end
    end

    task automatic send(input int i, input logic [7:0] d, input int npar, input logic pbit, input logic stopb);
        @(negedge clk);
        rsrx[i] = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            rsrx[i] = d[b];
            repeat (CPB) @(negedge clk);
        end
        if (npar != 0) begin
            rsrx[i] = pbit;
            repeat (CPB) @(negedge clk);
        end
        rsrx[i] = stopb;
        repeat (CPB) @(negedge clk);
        rsrx[i] = 1'b1;
    endtask

    task automatic drain(input int i, input string tag);
        int k;
        k = 0;
        while (k < 3000 && ((i == 0) ? (busy0 || fc0 != 0 || q_tx0.size() != 0) :
                            (i == 1) ? (busy1 || fc1 != 0 || q_tx1.size() != 0) :
                                       (busy2 || q_tx2.size() != 0))) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(k < 3000), 32'd1);
    endtask

    initial begin
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rstx", 32'(tx0), 32'd1);
        check("rst_rx_data", 32'(rxd0), 32'd0);
        check("rst_rx_valid", 32'(rxv0), 32'd0);
        check("rst_fifo_count", 32'(fc0), 32'd0);
        check("rst_overflow", 32'(ovf0), 32'd0);
        check("rst_tx_busy", 32'(busy0), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("echo_tx_ready_low", 32'(rdy0), 32'd0);
        check("host_tx_ready_idle", 32'(rdy2), 32'd1);

        q_rx0.push_back(8'hAA); q_tx0.push_back(8'hAA);
        send(0, 8'hAA, 0, 1'b0, 1'b1);
        q_rx0.push_back(8'hC3); q_tx0.push_back(8'hC3);
        send(0, 8'hC3, 0, 1'b0, 1'b1);
        drain(0, "t1_echo_drain");
        check("t1_fifo_count", 32'(fc0), 32'd0);
        check("t1_rx_data", 32'(rxd0), 32'hC3);
        check("t1_rx_pending", 32'(q_rx0.size()), 32'd0);

        send(0, 8'h55, 0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("t3_frame_err_pulses", 32'(n_ferr[0]), 32'd1);
        check("t3_rx_data_kept", 32'(rxd0), 32'hC3);
        check("t3_fifo_count", 32'(fc0), 32'd0);
        check("t3_no_echo", 32'(busy0), 32'd0);

        @(negedge clk);
        rsrx[0] = 1'b0;
        repeat (8) @(negedge clk);
        rsrx[0] = 1'b1;
        repeat (40) @(negedge clk);
        check("t5_glitch_no_frame_err", 32'(n_ferr[0]), 32'd1);
        check("t5_glitch_fifo_count", 32'(fc0), 32'd0);
        check("t5_glitch_tx_idle", 32'(busy0), 32'd0);
        q_rx0.push_back(8'h5A); q_tx0.push_back(8'h5A);
        send(0, 8'h5A, 0, 1'b0, 1'b1);
        drain(0, "t5_after_glitch_drain");
        check("t5_after_glitch_rx_data", 32'(rxd0), 32'h5A);

        send(1, 8'h07, 2, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("t2_parity_err_pulses", 32'(n_perr[1]), 32'd1);
        check("t2_fifo_count", 32'(fc1), 32'd0);
        check("t2_rstx_idle", 32'(tx1), 32'd1);
        check("t2_tx_idle", 32'(busy1), 32'd0);
        check("t2_rx_data_kept", 32'(rxd1), 32'd0);
        q_rx1.push_back(8'h07); q_tx1.push_back(8'h07);
        send(1, 8'h07, 2, 1'b1, 1'b1);
        q_rx1.push_back(8'h03); q_tx1.push_back(8'h03);
        send(1, 8'h03, 2, 1'b0, 1'b1);
        drain(1, "t2_parity_echo_drain");
        check("t2_good_rx_data", 32'(rxd1), 32'h03);
        send(1, 8'h0F, 2, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("t2_frame_beats_parity_ferr", 32'(n_ferr[1]), 32'd1);
        check("t2_frame_beats_parity_perr", 32'(n_perr[1]), 32'd1);

        foreach (q_tx0[j]) check("unused", 32'd0, 32'd0);
        for (int w = 1; w <= 4; w++) begin
            q_rx2.push_back(8'(w * 8'h11));
            send(2, 8'(w * 8'h11), 0, 1'b0, 1'b1);
        end
        repeat (4) @(negedge clk);
        check("t4_count_full", 32'(fc2), 32'd4);
        check("t4_no_overflow_yet", 32'(ovf2), 32'd0);
        q_rx2.push_back(8'h55);
        send(2, 8'h55, 0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("t4_count_after_drop", 32'(fc2), 32'd4);
        check("t4_overflow", 32'(ovf2), 32'd1);
        check("t4_rx_data_fifth", 32'(rxd2), 32'h55);

        txd2 = 8'h3C; txv2 = 1'b1;
        q_tx2.push_back(8'h3C);
        @(negedge clk);
        check("host_busy_after_capture", 32'(busy2), 32'd1);
        check("host_ready_low_busy", 32'(rdy2), 32'd0);
        check("host_rstx_start", 32'(tx2), 32'd0);
        txd2 = 8'h99;
        repeat (40) @(negedge clk);
        txv2 = 1'b0;
        drain(2, "host_tx_drain");

        txd2 = 8'h81; txv2 = 1'b1;
        @(negedge clk);
        txv2 = 1'b0;
        repeat (40) @(negedge clk);
        check("t6_busy_mid_frame", 32'(busy2), 32'd1);
        epoch++;
        rst = 1'b0;
        #1;
        check("t6_rstx_high", 32'(tx2), 32'd1);
        check("t6_busy_cleared", 32'(busy2), 32'd0);
        check("t6_fifo_count", 32'(fc2), 32'd0);
        check("t6_overflow_cleared", 32'(ovf2), 32'd0);
        check("t6_rx_data_cleared", 32'(rxd2), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("end_rx0_pending", 32'(q_rx0.size()), 32'd0);
        check("end_rx1_pending", 32'(q_rx1.size()), 32'd0);
        check("end_rx2_pending", 32'(q_rx2.size()), 32'd0);
        check("end_tx1_pending", 32'(q_tx1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
